// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory
// request at a time and buffers the returned word in a one-entry output
// register for the decoder. Redirects flush the buffer and cause any
// fetch still in flight to be dropped when its response arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_KILL
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;

  logic        consume;
  logic        free;
  logic        capture;
  logic [31:0] redirect_target;
  logic        unused_redirect_bits;

  // Request/handshake decode: a new request only starts from IDLE when the
  // buffer will have room; an outstanding request keeps its address stable.
  always_comb begin
    consume              = if_valid & ~stall;
    free                 = ~if_valid | consume;
    imem_req             = (state == IDLE) ? (free & ~redirect) : 1'b1;
    imem_addr            = (state == IDLE) ? pc : req_addr;
    capture              = imem_req & imem_valid & ~redirect & (state != WAIT_KILL);
    redirect_target      = {redirect_pc[31:2], 2'b00};
    unused_redirect_bits = ^redirect_pc[1:0];
  end

  assign if_pc4 = if_pc + 32'd4;

  // Fetch FSM, PC update and output buffer; redirect beats capture and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= 32'd0;
      if_pc    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_req) begin
            if (imem_valid) begin
              pc <= pc + 32'd4;
            end else begin
              req_addr <= pc;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_valid) begin
            state <= IDLE;
            if (!redirect) begin
              pc <= req_addr + 32'd4;
            end
          end else if (redirect) begin
            state <= WAIT_KILL;
          end
        end
        WAIT_KILL: begin
          if (imem_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (redirect) begin
        pc <= redirect_target;
      end

      if (redirect) begin
        if_valid <= 1'b0;
        if_inst  <= 32'd0;
      end else if (capture) begin
        if_valid <= 1'b1;
        if_inst  <= imem_rdata;
        if_pc    <= imem_addr;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the central control decoder.
- Holds the PC and issues one instruction-memory request at a time; memory may be zero-wait or variable-latency.
- Buffers the returned word in a one-entry IF output register that feeds the decoder and the register file read stage.
- Accepts stalls from downstream and PC redirects from branch/jump resolution, discarding any wrong-path fetch in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  downstream cannot accept if_inst this cycle
redirect  input  1  branch taken / jump: restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
imem_req  output  1  fetch request, combinational
imem_addr  output  32  fetch byte address, combinational, stable while request outstanding
imem_rdata  input  32  instruction word, sampled only when imem_valid=1
imem_valid  input  1  response for current request; may be asserted in same cycle as first imem_req
if_inst  output  32  buffered instruction to decoder
if_pc  output  32  address of if_inst
if_pc4  output  32  if_pc + 4 (mod 2^32), for link/branch-target use
if_valid  output  1  if_inst holds a live instruction

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC; state<=IDLE; if_valid<=0; if_inst<=0; if_pc<=0; kill cleared. rst overrides every other input.
- Memory shares rst and abandons any outstanding request on reset.
- imem_valid while imem_req=0 is ignored.
- consume = if_valid & ~stall. The buffer is "free" when ~if_valid | consume.
- States: IDLE (nothing outstanding), WAIT (request outstanding, result wanted), WAIT_KILL (request outstanding, result to be dropped).
- IDLE:
  - imem_req = free & ~redirect; imem_addr = pc.
  - If imem_req & imem_valid: capture the word (if_inst<=imem_rdata, if_pc<=pc, if_valid<=1); pc<=pc+4; stay IDLE.
  - If imem_req & ~imem_valid: req_addr<=pc; go to WAIT.
- WAIT:
  - imem_req=1; imem_addr=req_addr.
  - On imem_valid & ~redirect: capture as above with if_pc<=req_addr; pc<=req_addr+4; go to IDLE.
  - On redirect & ~imem_valid: go to WAIT_KILL.
  - On redirect & imem_valid: drop data; go to IDLE.
- WAIT_KILL:
  - imem_req=1; imem_addr=req_addr.
  - On imem_valid: drop data; go to IDLE.
  - A further redirect here only updates pc.
- Redirect, in any state:
  - pc<={redirect_pc[31:2],2'b00}.
  - if_valid<=0 and if_inst<=0 (NOP), even if stall=1. Redirect has priority over stall and over capture.
- Consume without capture in the same cycle: if_valid<=0. if_inst and if_pc hold.
- When stalled: if_valid=1 & stall=1 with no redirect leaves if_inst, if_pc and if_valid unchanged. No new request starts while the buffer is full and stalled.
- Capture guarantee: at capture time the buffer is always free, because a request only starts when free and the buffer cannot refill while waiting. No overwrite of an unconsumed instruction is possible.
- Throughput and latency:
  - Zero-wait memory with stall=0: one instruction per cycle, and if_inst is valid one cycle after imem_req.
  - N-cycle memory: N+1 cycles per instruction.
- Width and wrap: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. if_pc4 is computed from the registered if_pc.
- At most one request is outstanding. imem_addr must not change while imem_req=1 and imem_valid=0.

Test Plan:
- Reset, zero-wait memory (imem_valid=imem_req, rdata=addr^32'hA5A5_0000), stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_valid=1 from cycle 2; if_pc 0,4,8; if_pc4 4,8,12.
- 3-cycle latency memory -> imem_addr held at 0 for 3 cycles; one instruction every 4 cycles; if_pc sequence 0,4,8.
- stall=1 for 5 cycles while if_valid=1, if_pc=8 -> imem_req=0, if_inst/if_pc frozen; after release, next request at addr 12.
- Redirect to 32'h0000_0043 one cycle into a 3-cycle fetch of addr 4 -> the addr-4 response is dropped, if_valid=0, if_inst=0; next request is addr 32'h40; if_pc=0x40 on capture.
- Redirect and imem_valid in the same cycle, also with stall=1 -> data dropped, buffer flushed, next fetch at redirect target.
- RESET_PC=32'hFFFF_FFF8, zero-wait -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-wait -> next cycle imem_addr=RESET_PC, if_valid=0.
